// File: rtl/cgra_config_loader_if.sv
// Handshake bundle between the host config port, the config loader and the CGRA tiles.
interface cgra_config_loader_if #(
    parameter int NUM_TILES = 4,
    parameter int TILE_ID_W = 2,
    parameter int ADDR_W    = 3,
    parameter int OPT_W     = 59
);
    localparam int MSG_W = TILE_ID_W + ADDR_W + OPT_W;

    logic                        recv_cfg__en;
    logic [MSG_W-1:0]            recv_cfg__msg;
    logic                        recv_cfg__rdy;
    logic [NUM_TILES-1:0]        send_waddr__en;
    logic [NUM_TILES*ADDR_W-1:0] send_waddr__msg;
    logic [NUM_TILES-1:0]        send_waddr__rdy;
    logic [NUM_TILES-1:0]        send_wopt__en;
    logic [NUM_TILES*OPT_W-1:0]  send_wopt__msg;
    logic [NUM_TILES-1:0]        send_wopt__rdy;

    modport master (
        output recv_cfg__en, recv_cfg__msg, send_waddr__rdy, send_wopt__rdy,
        input  recv_cfg__rdy, send_waddr__en, send_waddr__msg, send_wopt__en, send_wopt__msg
    );

    modport slave (
        input  recv_cfg__en, recv_cfg__msg, send_waddr__rdy, send_wopt__rdy,
        output recv_cfg__rdy, send_waddr__en, send_waddr__msg, send_wopt__en, send_wopt__msg
    );
endinterface

// File: rtl/cgra_config_loader.sv
// Buffers a host configuration burst in a small FIFO and dispatches each word,
// address and opt together, to the tile named in its tile-id field.
module cgra_config_loader #(
    parameter int NUM_TILES  = 4,
    parameter int TILE_ID_W  = 2,
    parameter int ADDR_W     = 3,
    parameter int OPT_W      = 59,
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_start,
    input  logic [LEN_W-1:0]     cfg_len,
    cgra_config_loader_if.slave  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    localparam int MSG_W = TILE_ID_W + ADDR_W + OPT_W;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]     FULL_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [TILE_ID_W:0]   TILE_LIMIT = (TILE_ID_W + 1)'(NUM_TILES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic [LEN_W-1:0]   disp_cnt_q, disp_cnt_d;
    logic               err_q, err_d;
    logic [MSG_W-1:0]   fifo_q [FIFO_DEPTH];
    logic [MSG_W-1:0]   fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic                  in_burst_s, empty_s, full_s, rdy_s, push_s;
    logic                  head_ok_s, bad_s, fire_s, pop_s;
    logic [MSG_W-1:0]      head_s;
    logic [TILE_ID_W-1:0]  head_tile_s;
    logic [ADDR_W-1:0]     head_addr_s;
    logic [OPT_W-1:0]      head_opt_s;

    assign in_burst_s  = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    assign empty_s     = (count_q == {CNT_W{1'b0}});
    assign full_s      = (count_q == FULL_CNT);
    assign rdy_s       = (state_q == ST_LOAD) && !full_s && (acc_cnt_q < len_q);
    assign push_s      = bus.recv_cfg__en && rdy_s;
    assign head_s      = fifo_q[rd_ptr_q];
    assign head_tile_s = head_s[MSG_W-1 -: TILE_ID_W];
    assign head_addr_s = head_s[OPT_W +: ADDR_W];
    assign head_opt_s  = head_s[OPT_W-1:0];
    assign head_ok_s   = ({1'b0, head_tile_s} < TILE_LIMIT);
    assign bad_s       = in_burst_s && !empty_s && !head_ok_s;
    assign pop_s       = fire_s || bad_s;

    assign bus.recv_cfg__rdy = rdy_s;
    assign busy = in_burst_s;
    assign done = (state_q == ST_DONE);
    assign err  = err_q;

    // Steer the FIFO head to its tile; both fields move in the same cycle or not at all.
    always_comb begin
        bus.send_waddr__en  = {NUM_TILES{1'b0}};
        bus.send_wopt__en   = {NUM_TILES{1'b0}};
        bus.send_waddr__msg = {(NUM_TILES*ADDR_W){1'b0}};
        bus.send_wopt__msg  = {(NUM_TILES*OPT_W){1'b0}};
        fire_s              = 1'b0;
        for (int t = 0; t < NUM_TILES; t++) begin
            if (in_burst_s && !empty_s && (head_tile_s == TILE_ID_W'(t)) &&
                bus.send_waddr__rdy[t] && bus.send_wopt__rdy[t]) begin
                bus.send_waddr__en[t]                 = 1'b1;
                bus.send_wopt__en[t]                  = 1'b1;
                bus.send_waddr__msg[t*ADDR_W +: ADDR_W] = head_addr_s;
                bus.send_wopt__msg[t*OPT_W +: OPT_W]    = head_opt_s;
                fire_s                                = 1'b1;
            end else begin
                bus.send_waddr__en[t] = 1'b0;
                bus.send_wopt__en[t]  = 1'b0;
            end
        end
    end

    // Next-state, FIFO bookkeeping and burst counters.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        acc_cnt_d  = acc_cnt_q;
        disp_cnt_d = disp_cnt_q;
        err_d      = err_q;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q + CNT_W'(push_s) - CNT_W'(pop_s);

        if (push_s) begin
            fifo_d[wr_ptr_q] = bus.recv_cfg__msg;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            acc_cnt_d        = acc_cnt_q + LEN_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d   = rd_ptr_q + PTR_W'(1);
            disp_cnt_d = disp_cnt_q + LEN_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        if (bad_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        // DRAIN exit looks at post-update counts so DONE follows the last dispatch directly.
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    if (cfg_len != {LEN_W{1'b0}}) begin
                        state_d    = ST_LOAD;
                        len_d      = cfg_len;
                        acc_cnt_d  = {LEN_W{1'b0}};
                        disp_cnt_d = {LEN_W{1'b0}};
                        err_d      = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (push_s && (acc_cnt_d == len_q)) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DRAIN: begin
                if ((count_d == {CNT_W{1'b0}}) && (disp_cnt_d == len_q)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and FIFO registers; reset discards any buffered words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            len_q      <= {LEN_W{1'b0}};
            acc_cnt_q  <= {LEN_W{1'b0}};
            disp_cnt_q <= {LEN_W{1'b0}};
            err_q      <= 1'b0;
            fifo_q     <= '{default: {MSG_W{1'b0}}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            acc_cnt_q  <= acc_cnt_d;
            disp_cnt_q <= disp_cnt_d;
            err_q      <= err_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end
endmodule

// File: tb/tb_cgra_config_loader.sv
// Randomized scoreboard bench for cgra_config_loader: host words queue up as expected
// tile transfers, and a negedge monitor matches every dispatch against them in order.
`timescale 1ns/1ps
module tb_cgra_config_loader;
    localparam int NT = 4;
    localparam int TW = 2;
    localparam int AW = 3;
    localparam int OW = 59;
    localparam int FD = 4;
    localparam int LW = 8;
    localparam int MW = TW + AW + OW;

    typedef struct {
        logic [TW-1:0] tile;
        logic [AW-1:0] addr;
        logic [OW-1:0] opt;
        int            pcyc;
    } word_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cfg_start;
    logic [LW-1:0] cfg_len;
    logic          busy, done, err;
    logic          cfg_start3;
    logic [LW-1:0] cfg_len3;
    logic          busy3, done3, err3;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    word_t host_q[$];
    word_t sb_q[$];
    int    log3[$];

    bit      mon_on = 1'b0;
    bit      host_gaps = 1'b0;
    bit      strict_lat = 1'b0;
    bit      busy_seen = 1'b0;
    int      rdy_mode = 0;
    logic [NT-1:0] man_wrdy = 4'h0;
    logic [NT-1:0] man_ordy = 4'h0;
    int      burst_len = 0;
    int      burst_disp = 0;
    int      done_due = -1;
    int      done_cnt = 0;
    int      en_events = 0;
    int      done3_cnt = 0;
    int      pair3_bad = 0;

    cgra_config_loader_if #(.NUM_TILES(NT), .TILE_ID_W(TW), .ADDR_W(AW), .OPT_W(OW)) bus ();
    cgra_config_loader_if #(.NUM_TILES(3), .TILE_ID_W(TW), .ADDR_W(AW), .OPT_W(OW)) bus3 ();

    cgra_config_loader #(.NUM_TILES(NT), .TILE_ID_W(TW), .ADDR_W(AW), .OPT_W(OW),
                         .FIFO_DEPTH(FD), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_len(cfg_len),
        .bus(bus), .busy(busy), .done(done), .err(err)
    );

    cgra_config_loader #(.NUM_TILES(3), .TILE_ID_W(TW), .ADDR_W(AW), .OPT_W(OW),
                         .FIFO_DEPTH(FD), .LEN_W(LW)) dut3 (
        .clk(clk), .reset(reset), .cfg_start(cfg_start3), .cfg_len(cfg_len3),
        .bus(bus3), .busy(busy3), .done(done3), .err(err3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic word_t mk(input int tile, input int addr, input logic [OW-1:0] opt);
        word_t w;
        w.tile = TW'(tile);
        w.addr = AW'(addr);
        w.opt  = opt;
        w.pcyc = 0;
        return w;
    endfunction

    function automatic word_t rnd_word();
        return mk(int'($urandom_range(NT-1, 0)), int'($urandom_range(7, 0)),
                  OW'({$urandom, $urandom}));
    endfunction

    // Host driver: offer the oldest queued word whenever the loader reports ready.
    initial begin
        word_t w;
        bus.recv_cfg__en  = 1'b0;
        bus.recv_cfg__msg = {MW{1'b0}};
        forever begin
            @(posedge clk); #1;
            bus.recv_cfg__en = 1'b0;
            if (host_q.size() > 0 && bus.recv_cfg__rdy === 1'b1 &&
                (!host_gaps || $urandom_range(3, 0) != 0)) begin
                w = host_q.pop_front();
                w.pcyc = cyc;
                sb_q.push_back(w);
                bus.recv_cfg__en  = 1'b1;
                bus.recv_cfg__msg = {w.tile, w.addr, w.opt};
            end
        end
    end

    // Tile-ready driver: fixed, random or toggling back-pressure.
    initial begin
        logic tg;
        tg = 1'b0;
        bus.send_waddr__rdy = 4'h0;
        bus.send_wopt__rdy  = 4'h0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                1: begin
                    bus.send_waddr__rdy = NT'($urandom);
                    bus.send_wopt__rdy  = NT'($urandom);
                end
                2: begin
                    tg = ~tg;
                    bus.send_waddr__rdy = {NT{tg}};
                    bus.send_wopt__rdy  = {NT{tg}};
                end
                default: begin
                    bus.send_waddr__rdy = man_wrdy;
                    bus.send_wopt__rdy  = man_ordy;
                end
            endcase
        end
    end

    // Monitor: compare every tile transfer and the done pulse with the reference model.
    initial begin
        word_t w;
        int t;
        logic [NT*AW-1:0] exp_wa;
        logic [NT*OW-1:0] exp_wo;
        forever begin
            @(negedge clk);
            if (bus.send_waddr__en != 4'h0) en_events++;
            if (mon_on) begin
                check("en_pair", bus.send_wopt__en, bus.send_waddr__en);
                if (bus.send_waddr__en == 4'h0) begin
                    check("idle_msgs_zero",
                          64'((|bus.send_waddr__msg) | (|bus.send_wopt__msg)), 64'd0);
                end else begin
                    check("en_onehot", 64'($onehot(bus.send_waddr__en)), 64'd1);
                    check("en_without_rdy",
                          bus.send_waddr__en & ~(bus.send_waddr__rdy & bus.send_wopt__rdy), 64'd0);
                    if (sb_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_dispatch: en=0x%0h, expected no transfer", bus.send_waddr__en);
                    end else begin
                        w = sb_q.pop_front();
                        t = int'(w.tile);
                        exp_wa = {(NT*AW){1'b0}};
                        exp_wo = {(NT*OW){1'b0}};
                        exp_wa[t*AW +: AW] = w.addr;
                        exp_wo[t*OW +: OW] = w.opt;
                        check("tile_en", bus.send_waddr__en, NT'(1) << t);
                        check("waddr_bus", bus.send_waddr__msg, exp_wa);
                        check("wopt_slice", bus.send_wopt__msg[t*OW +: OW], w.opt);
                        check("wopt_bus_match", 64'(bus.send_wopt__msg != exp_wo), 64'd0);
                        if (strict_lat) check("latency", cyc - w.pcyc, 64'd1);
                        else            check("no_bypass", 64'(cyc > w.pcyc), 64'd1);
                        burst_disp++;
                        if (burst_disp == burst_len) done_due = cyc + 1;
                    end
                end
                check("done", done, cyc == done_due);
                if (done) done_cnt++;
                if (busy) busy_seen = 1'b1;
            end
        end
    end

    // Monitor for the three-tile build used for the out-of-range tile case.
    initial begin
        forever begin
            @(negedge clk);
            if (bus3.send_waddr__en != bus3.send_wopt__en) pair3_bad++;
            for (int i = 0; i < 3; i++) begin
                if (bus3.send_waddr__en[i]) log3.push_back(int'(bus3.send_waddr__msg[i*AW +: AW]));
            end
            if (done3) done3_cnt++;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_burst(input int len);
        @(posedge clk); #1;
        cfg_start  = 1'b1;
        cfg_len    = LW'(len);
        burst_len  = len;
        burst_disp = 0;
        done_cnt   = 0;
        if (len == 0) done_due = cyc + 1;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        if (len != 0) begin
            check("rdy_after_start", bus.recv_cfg__rdy, 64'd1);
            check("busy_after_start", busy, 64'd1);
        end
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no done within %0d cycles, expected one", name, budget);
        end
        repeat (3) @(posedge clk);
        check({name, "_done_once"}, done_cnt, 64'd1);
        check({name, "_sb_drained"}, sb_q.size(), 64'd0);
        check({name, "_disp_count"}, burst_disp, burst_len);
    endtask

    task automatic send3(input int tile, input int addr, input int opt);
        int k;
        k = 0;
        while (bus3.recv_cfg__rdy !== 1'b1 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("dut3_rdy", bus3.recv_cfg__rdy, 64'd1);
        bus3.recv_cfg__en  = 1'b1;
        bus3.recv_cfg__msg = {TW'(tile), AW'(addr), OW'(opt)};
        @(posedge clk); #1;
        bus3.recv_cfg__en = 1'b0;
    endtask

    initial begin
        int k;
        int rdy_bad;
        int ev0;
        int len;
        reset       = 1'b0;
        cfg_start   = 1'b0;
        cfg_len     = 8'd0;
        cfg_start3  = 1'b0;
        cfg_len3    = 8'd0;
        bus3.recv_cfg__en   = 1'b0;
        bus3.recv_cfg__msg  = {MW{1'b0}};
        bus3.send_waddr__rdy = 3'b111;
        bus3.send_wopt__rdy  = 3'b111;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rdy", bus.recv_cfg__rdy, 64'd0);
        check("rst_waddr_en", bus.send_waddr__en, 64'd0);
        check("rst_wopt_en", bus.send_wopt__en, 64'd0);
        check("rst_msgs", 64'((|bus.send_waddr__msg) | (|bus.send_wopt__msg)), 64'd0);
        check("rst_busy", busy, 64'd0);
        check("rst_done", done, 64'd0);
        check("rst_err", err, 64'd0);
        @(posedge clk); #1;
        reset  = 1'b1;
        mon_on = 1'b1;

        // Four words, one per tile, all tiles ready: one-cycle latency.
        man_wrdy = 4'hF;
        man_ordy = 4'hF;
        strict_lat = 1'b1;
        for (int i = 0; i < 4; i++) host_q.push_back(mk(i, i + 1, OW'(64'h456 + 64'(i))));
        start_burst(4);
        wait_done(60, "basic");
        strict_lat = 1'b0;

        // Tile 2 opt side stalled while its address side is ready.
        man_ordy = 4'hB;
        for (int i = 0; i < 5; i++) host_q.push_back(mk(2, i, OW'({$urandom, $urandom})));
        start_burst(5);
        repeat (10) @(negedge clk);
        check("stall_host_left", host_q.size(), 64'd1);
        check("stall_buffered", sb_q.size(), 64'd4);
        check("stall_rdy_low", bus.recv_cfg__rdy, 64'd0);
        check("stall_no_dispatch", burst_disp, 64'd0);
        man_ordy = 4'hF;
        wait_done(60, "stall");

        // Zero-length burst.
        busy_seen = 1'b0;
        ev0 = en_events;
        start_burst(0);
        repeat (4) @(negedge clk);
        check("len0_done_once", done_cnt, 64'd1);
        check("len0_busy_never", busy_seen, 64'd0);
        check("len0_no_enables", en_events - ev0, 64'd0);

        // Six-word burst, toggling ready, host offering more than the burst length.
        rdy_mode = 2;
        for (int i = 0; i < 8; i++) host_q.push_back(rnd_word());
        start_burst(6);
        k = 0;
        while (host_q.size() > 2 && k < 200) begin
            @(negedge clk);
            k++;
        end
        rdy_bad = 0;
        k = 0;
        do begin
            @(negedge clk);
            if (busy && bus.recv_cfg__rdy) rdy_bad++;
            k++;
        end while (!done && k < 200);
        check("drain_rdy_low", rdy_bad, 64'd0);
        wait_done(60, "len6");
        check("len6_extra_not_taken", host_q.size(), 64'd2);
        host_q.delete();
        rdy_mode = 0;

        // Random bursts with random back-pressure and host gaps.
        rdy_mode = 1;
        host_gaps = 1'b1;
        for (int b = 0; b < 8; b++) begin
            len = int'($urandom_range(20, 1));
            for (int i = 0; i < len; i++) host_q.push_back(rnd_word());
            start_burst(len);
            wait_done(1000, "random");
        end
        rdy_mode = 0;
        host_gaps = 1'b0;

        // Asynchronous reset with two words buffered.
        man_wrdy = 4'h0;
        man_ordy = 4'h0;
        host_q.push_back(rnd_word());
        host_q.push_back(rnd_word());
        start_burst(8);
        repeat (5) @(negedge clk);
        check("pre_reset_buffered", sb_q.size(), 64'd2);
        #2;
        mon_on = 1'b0;
        reset  = 1'b0;
        #1;
        check("arst_rdy", bus.recv_cfg__rdy, 64'd0);
        check("arst_en", 64'({bus.send_waddr__en, bus.send_wopt__en}), 64'd0);
        check("arst_msgs", 64'((|bus.send_waddr__msg) | (|bus.send_wopt__msg)), 64'd0);
        check("arst_busy", busy, 64'd0);
        check("arst_done", done, 64'd0);
        check("arst_err", err, 64'd0);
        host_q.delete();
        sb_q.delete();
        done_due = -1;
        man_wrdy = 4'hF;
        man_ordy = 4'hF;
        @(posedge clk); #1;
        reset = 1'b1;
        ev0 = en_events;
        mon_on = 1'b1;
        repeat (10) @(negedge clk);
        check("arst_discarded", en_events - ev0, 64'd0);
        for (int i = 0; i < 3; i++) host_q.push_back(rnd_word());
        start_burst(3);
        wait_done(60, "post_reset");

        // Three-tile build: a word to tile 3 is dropped and flags err.
        @(posedge clk); #1;
        done3_cnt = 0;
        log3.delete();
        cfg_start3 = 1'b1;
        cfg_len3   = 8'd3;
        @(posedge clk); #1;
        cfg_start3 = 1'b0;
        send3(0, 5, 1);
        send3(3, 6, 2);
        send3(1, 7, 3);
        k = 0;
        while (done3_cnt == 0 && k < 40) begin
            @(posedge clk);
            k++;
        end
        repeat (2) @(posedge clk);
        check("t3_done_once", done3_cnt, 64'd1);
        check("t3_dispatches", log3.size(), 64'd2);
        if (log3.size() == 2) begin
            check("t3_first_addr", log3[0], 64'd5);
            check("t3_second_addr", log3[1], 64'd7);
        end
        check("t3_pairing", pair3_bad, 64'd0);
        check("t3_err_set", err3, 64'd1);
        repeat (5) @(posedge clk);
        check("t3_err_sticky", err3, 64'd1);
        @(posedge clk); #1;
        cfg_start3 = 1'b1;
        cfg_len3   = 8'd1;
        @(posedge clk); #1;
        cfg_start3 = 1'b0;
        check("t3_err_cleared", err3, 64'd0);
        send3(2, 4, 9);
        repeat (4) @(posedge clk);
        check("t3_done_again", done3_cnt, 64'd2);
        check("t3_err_stays_clear", err3, 64'd0);
        check("t3_last_addr", log3.size() == 3 ? log3[2] : -1, 64'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cgra_config_loader.md
# cgra_config_loader

Configuration loader sitting directly upstream of the 2x2 King-mesh CGRA. It accepts a burst of configuration words from the host over one en/rdy port, buffers them in a small FIFO, and dispatches each word to the addressed tile's `recv_waddr`/`recv_wopt` pair. Both fields of a word are delivered atomically in the same cycle. The block counts words against a programmed length and pulses `done` when the whole burst has reached the tiles.

## Interface
- `NUM_TILES`, 4: number of CGRA tiles fed.
- `TILE_ID_W`, 2: width of the tile-id field.
- `ADDR_W`, 3: per-tile config-memory address width.
- `OPT_W`, 59: per-tile config-word (opt) width.
- `FIFO_DEPTH`, 4: buffer entries; power of two, at least 2.
- `LEN_W`, 8: width of the burst-length field.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `cfg_start` in 1: one-cycle pulse that starts a burst; sampled in IDLE only.
- `cfg_len` in `LEN_W`: number of words in the burst; sampled with `cfg_start`.
- `recv_cfg__en` in 1: host word transfer; asserted only while `recv_cfg__rdy`=1.
- `recv_cfg__msg` in `TILE_ID_W+ADDR_W+OPT_W` (64): `{tile_id, addr, opt}`, with `tile_id` in the MSBs.
- `recv_cfg__rdy` out 1: loader can accept a word this cycle.
- `send_waddr__en` out `NUM_TILES`: per-tile address transfer.
- `send_waddr__msg` out `NUM_TILES*ADDR_W`: slice t is tile t's address.
- `send_waddr__rdy` in `NUM_TILES`: tile ready for an address.
- `send_wopt__en` out `NUM_TILES`: per-tile opt transfer.
- `send_wopt__msg` out `NUM_TILES*OPT_W`: slice t is tile t's opt word.
- `send_wopt__rdy` in `NUM_TILES`: tile ready for an opt word.
- `busy` out 1: high in LOAD and DRAIN.
- `done` out 1: one-cycle pulse at the end of a burst.
- `err` out 1: sticky flag; set when a word has `tile_id >= NUM_TILES`.

## Operation
- FSM states: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - `cfg_start`=1 and `cfg_len`!=0: latch the length, clear `acc_cnt`, `disp_cnt` and `err`, go to LOAD.
  - `cfg_start`=1 and `cfg_len`=0: go to DONE.
- LOAD:
  - `recv_cfg__rdy` = FIFO not full AND `acc_cnt` < len.
  - Each `recv_cfg__en` pushes one word and increments `acc_cnt`.
  - When the push makes `acc_cnt` == len, go to DRAIN.
- DRAIN: `recv_cfg__rdy`=0. When the FIFO is empty and `disp_cnt` == len, go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE. `busy`=0.
- Dispatch (LOAD and DRAIN, FIFO not empty). Let the FIFO head have tile id h.
  - h < `NUM_TILES`: `send_waddr__en[h]` and `send_wopt__en[h]` are both 1 iff `send_waddr__rdy[h]` AND `send_wopt__rdy[h]`; otherwise both are 0. Never assert one without the other.
  - When the enables fire: pop the head, increment `disp_cnt`.
  - h >= `NUM_TILES` (only possible when `NUM_TILES` < 2^`TILE_ID_W`): pop unconditionally, increment `disp_cnt`, set `err`. No enable is asserted.
- Message slices:
  - Target slice carries the head's addr/opt.
  - Non-target slices are driven 0.
  - All slices are 0 when no enable is asserted.
- At most one word is dispatched per cycle. Dispatch is in-order: no bypass of a blocked head.
- `cfg_start` in any state other than IDLE is ignored.
- `recv_cfg__en` while `recv_cfg__rdy`=0 is a protocol violation. The word is not stored and counters do not change.

## Timing
- Reset (async assert, whatever the state) gives:
  - state IDLE, FIFO empty, counters 0;
  - `recv_cfg__rdy`=0, all send enables and messages 0;
  - `busy`=0, `done`=0, `err`=0.
- Reset mid-burst discards buffered words. No enable may glitch high during reset.
- `cfg_start` at cycle N: LOAD and `recv_cfg__rdy`=1 at N+1.
- Word pushed at cycle N: it is at the FIFO head at N+1 and can dispatch at N+1 at the earliest. No push-to-send bypass.
- Send enables are combinational from the registered head plus the `*__rdy` inputs. They have no path from `recv_cfg__*`.
- Full FIFO with a simultaneous pop: `recv_cfg__rdy` stays 0 that cycle. rdy is a function of registered occupancy only.
- Simultaneous push and pop when not full: occupancy is unchanged.
- Pointers wrap modulo `FIFO_DEPTH`.
- Last word dispatched at cycle M with the FIFO now empty: DONE at M+1, `done` high during M+1, IDLE at M+2.
- Sustained throughput with all tiles ready: 1 word/cycle.

## Test plan
- Reset, then `cfg_start` with `cfg_len`=4 and words to tiles 0,1,2,3 (addr 1..4, opt 0x456+i), all rdy=1:
  - each `send_*__en` is one-hot in the matching bit, 1 cycle after its push;
  - `done` pulses exactly once, 1 cycle after the 4th dispatch.
- Tile 2 `send_wopt__rdy`=0 with `send_waddr__rdy`=1, head targeting tile 2:
  - both tile-2 enables stay 0;
  - the FIFO fills after 4 pushes and `recv_cfg__rdy` drops;
  - releasing rdy drains the words in order.
- `cfg_len`=0 start: DONE on the next cycle, `done` pulses, no enables asserted, `busy` never 1.
- `cfg_len`=6 with FIFO_DEPTH=4 and rdy toggling every cycle:
  - exactly 6 dispatches in push order;
  - `acc_cnt` stops at 6 and `recv_cfg__rdy`=0 in DRAIN.
- Async `reset` low mid-burst with 2 words buffered:
  - all outputs are 0 immediately;
  - after release, the buffered words are never emitted and a new burst works normally.
- Built with `NUM_TILES`=3, push a word with `tile_id`=3:
  - no enable asserted, word consumed, `err`=1 sticky until the next `cfg_start`;
  - `done` still pulses.
